// File: rtl/salu_pkg.sv
// Shared scalar-ALU definitions: opcode encoding, branch classification and
// the writeback payload carried through the execute-stage buffer.
package salu_pkg;

    localparam int unsigned SALU_DATA_W     = 32;
    localparam int unsigned SALU_REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_BEQ  = 4'd10,
        ALU_BNE  = 4'd11,
        ALU_BLT  = 4'd12,
        ALU_BGE  = 4'd13,
        ALU_BLTU = 4'd14,
        ALU_BGEU = 4'd15
    } alu_op_e;

    // Branch opcodes occupy the top of the encoding space.
    function automatic logic is_branch_op(input alu_op_e op);
        return (op >= ALU_BEQ);
    endfunction

    typedef struct packed {
        logic [SALU_REG_ADDR_W-1:0] rd_addr;
        logic                       rd_we;
        logic [SALU_DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/salu_skid_buf.sv
// Two-slot valid/ready register slice: an output register plus one skid entry,
// with ready derived only from the skid valid bit.
module salu_skid_buf #(
    parameter type T = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic out_valid_q, out_valid_d;
    logic skid_valid_q, skid_valid_d;
    T     out_q, out_d;
    T     skid_q, skid_d;
    logic push;
    logic drain;

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q;

    assign push  = in_valid_i && in_ready_o && !flush_i;
    assign drain = out_valid_q && out_ready_i;

    // Flush beats drain and push; a full slice never sees a push while draining.
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_d        = out_q;
        skid_d       = skid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
        end else if (push && (!out_valid_q || drain)) begin
            out_d       = in_data_i;
            out_valid_d = 1'b1;
        end else if (push) begin
            skid_d       = in_data_i;
            skid_valid_d = 1'b1;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/salu_ex_stage.sv
// Scalar execute stage: forwards decoded operands to the salu, buffers results
// for writeback and reports resolved branches to fetch as a registered pulse.
module salu_ex_stage
    import salu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SALU_DATA_W,
    parameter int unsigned REG_ADDR_W = SALU_REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    output logic                  id_ready_o,
    input  logic [3:0]            id_alu_op_i,
    input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_rd_we_i,
    input  logic                  id_is_branch_i,
    input  logic [DATA_WIDTH-1:0] id_pc_i,
    input  logic [DATA_WIDTH-1:0] id_imm_i,
    output logic [3:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_rs1_o,
    output logic [DATA_WIDTH-1:0] alu_rs2_o,
    input  logic [DATA_WIDTH-1:0] alu_res_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [REG_ADDR_W-1:0] wb_rd_addr_o,
    output logic                  wb_rd_we_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  br_valid_o,
    output logic                  br_taken_o,
    output logic [DATA_WIDTH-1:0] br_target_o
);

    wb_entry_t             wb_in;
    wb_entry_t             wb_out;
    logic                  wb_in_valid;
    logic                  br_accept;
    logic                  br_valid_q, br_valid_d;
    logic                  br_taken_q, br_taken_d;
    logic [DATA_WIDTH-1:0] br_target_q, br_target_d;

    assign alu_op_o  = id_alu_op_i;
    assign alu_rs1_o = id_rs1_data_i;
    assign alu_rs2_o = id_rs2_data_i;

    // Writes to x0 still flow through so ordering is preserved, just disarmed.
    always_comb begin
        wb_in         = '0;
        wb_in.rd_addr = SALU_REG_ADDR_W'(id_rd_addr_i);
        wb_in.rd_we   = id_rd_we_i && (id_rd_addr_i != '0);
        wb_in.data    = SALU_DATA_W'(alu_res_i);
    end

    assign wb_in_valid = id_valid_i && !id_is_branch_i;

    salu_skid_buf #(
        .T(wb_entry_t)
    ) u_wb_buf (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .in_valid_i (wb_in_valid),
        .in_ready_o (id_ready_o),
        .in_data_i  (wb_in),
        .out_valid_o(wb_valid_o),
        .out_ready_i(wb_ready_i),
        .out_data_o (wb_out)
    );

    assign wb_rd_addr_o = REG_ADDR_W'(wb_out.rd_addr);
    assign wb_rd_we_o   = wb_out.rd_we;
    assign wb_data_o    = DATA_WIDTH'(wb_out.data);

    assign br_accept = id_valid_i && id_ready_o && !flush_i && id_is_branch_i;

    // Taken/target hold between pulses so fetch can sample them late.
    always_comb begin
        br_valid_d  = br_accept;
        br_taken_d  = br_taken_q;
        br_target_d = br_target_q;
        if (br_accept) begin
            br_taken_d  = alu_res_i[0];
            br_target_d = id_pc_i + id_imm_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            br_valid_q  <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            br_valid_q  <= br_valid_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign br_valid_o  = br_valid_q;
    assign br_taken_o  = br_taken_q;
    assign br_target_o = br_target_q;

endmodule

// File: tb/tb_salu_ex_stage.sv
// Directed bench for salu_ex_stage: a small salu model answers the operand
// outputs, a scoreboard queue holds hand-computed writeback/branch results.
module tb_salu_ex_stage;
    import salu_pkg::*;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_exp_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        id_valid_i;
    logic        id_ready_o;
    logic [3:0]  id_alu_op_i;
    logic [31:0] id_rs1_data_i;
    logic [31:0] id_rs2_data_i;
    logic [4:0]  id_rd_addr_i;
    logic        id_rd_we_i;
    logic        id_is_branch_i;
    logic [31:0] id_pc_i;
    logic [31:0] id_imm_i;
    logic [3:0]  alu_op_o;
    logic [31:0] alu_rs1_o;
    logic [31:0] alu_rs2_o;
    logic [31:0] alu_res_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_addr_o;
    logic        wb_rd_we_o;
    logic [31:0] wb_data_o;
    logic        br_valid_o;
    logic        br_taken_o;
    logic [31:0] br_target_o;

    int total = 0;
    int bad   = 0;

    wb_exp_t wb_q[$];
    br_exp_t br_q[$];
    wb_exp_t cur_wb_exp;
    br_exp_t cur_br_exp;

    always #5 clk_i = ~clk_i;

    salu_ex_stage dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .id_valid_i    (id_valid_i),
        .id_ready_o    (id_ready_o),
        .id_alu_op_i   (id_alu_op_i),
        .id_rs1_data_i (id_rs1_data_i),
        .id_rs2_data_i (id_rs2_data_i),
        .id_rd_addr_i  (id_rd_addr_i),
        .id_rd_we_i    (id_rd_we_i),
        .id_is_branch_i(id_is_branch_i),
        .id_pc_i       (id_pc_i),
        .id_imm_i      (id_imm_i),
        .alu_op_o      (alu_op_o),
        .alu_rs1_o     (alu_rs1_o),
        .alu_rs2_o     (alu_rs2_o),
        .alu_res_i     (alu_res_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_rd_addr_o  (wb_rd_addr_o),
        .wb_rd_we_o    (wb_rd_we_o),
        .wb_data_o     (wb_data_o),
        .br_valid_o    (br_valid_o),
        .br_taken_o    (br_taken_o),
        .br_target_o   (br_target_o)
    );

    // Stand-in for the salu, covering only the opcodes used below.
    always_comb begin
        alu_res_i = '0;
        case (alu_op_o)
            ALU_ADD: alu_res_i = alu_rs1_o + alu_rs2_o;
            ALU_SUB: alu_res_i = alu_rs1_o - alu_rs2_o;
            ALU_XOR: alu_res_i = alu_rs1_o ^ alu_rs2_o;
            ALU_BEQ: alu_res_i = 32'(alu_rs1_o == alu_rs2_o);
            ALU_BNE: alu_res_i = 32'(alu_rs1_o != alu_rs2_o);
            ALU_BLT: alu_res_i = 32'($signed(alu_rs1_o) < $signed(alu_rs2_o));
            default: alu_res_i = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: pops on each output event, pushes on each accepted op.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            wb_q.delete();
            br_q.delete();
        end else begin
            if (flush_i) begin
                wb_q.delete();
            end else if (wb_valid_o && wb_ready_i) begin
                total++;
                if (wb_q.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected: got rd=%0d we=%0b data=%h want none",
                             wb_rd_addr_o, wb_rd_we_o, wb_data_o);
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    if ({wb_rd_addr_o, wb_rd_we_o, wb_data_o} !== e) begin
                        bad++;
                        $display("FAIL wb_entry: got rd=%0d we=%0b data=%h want rd=%0d we=%0b data=%h",
                                 wb_rd_addr_o, wb_rd_we_o, wb_data_o, e.rd, e.we, e.data);
                    end
                end
            end
            if (br_valid_o) begin
                total++;
                if (br_q.size() == 0) begin
                    bad++;
                    $display("FAIL br_unexpected: got taken=%0b target=%h want none",
                             br_taken_o, br_target_o);
                end else begin
                    br_exp_t b;
                    b = br_q.pop_front();
                    if ({br_taken_o, br_target_o} !== b) begin
                        bad++;
                        $display("FAIL br_entry: got taken=%0b target=%h want taken=%0b target=%h",
                                 br_taken_o, br_target_o, b.taken, b.target);
                    end
                end
            end
            if (id_valid_i && id_ready_o && !flush_i) begin
                if (id_is_branch_i) br_q.push_back(cur_br_exp);
                else                wb_q.push_back(cur_wb_exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        id_valid_i = 1'b0;
    endtask

    task automatic drive_wb(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic we, input wb_exp_t e);
        id_valid_i     = 1'b1;
        id_alu_op_i    = op;
        id_rs1_data_i  = a;
        id_rs2_data_i  = b;
        id_rd_addr_i   = rd;
        id_rd_we_i     = we;
        id_is_branch_i = is_branch_op(op);
        id_pc_i        = '0;
        id_imm_i       = '0;
        cur_wb_exp     = e;
    endtask

    task automatic drive_br(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm, input br_exp_t e);
        id_valid_i     = 1'b1;
        id_alu_op_i    = op;
        id_rs1_data_i  = a;
        id_rs2_data_i  = b;
        id_rd_addr_i   = '0;
        id_rd_we_i     = 1'b0;
        id_is_branch_i = is_branch_op(op);
        id_pc_i        = pc;
        id_imm_i       = imm;
        cur_br_exp     = e;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1;
        id_valid_i = 1'b0; id_alu_op_i = '0; id_rs1_data_i = '0; id_rs2_data_i = '0;
        id_rd_addr_i = '0; id_rd_we_i = 1'b0; id_is_branch_i = 1'b0;
        id_pc_i = '0; id_imm_i = '0; cur_wb_exp = '0; cur_br_exp = '0;

        // Reset state
        cyc(); cyc();
        @(negedge clk_i);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_br_valid", 32'(br_valid_o), 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_br_target", br_target_o, 32'd0);
        cyc();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ready", 32'(id_ready_o), 32'd1);
        cyc();

        // ADD 5+3 -> x7, visible one cycle after acceptance
        drive_wb(ALU_ADD, 32'd5, 32'd3, 5'd7, 1'b1, '{rd: 5'd7, we: 1'b1, data: 32'd8});
        cyc(); idle();
        @(negedge clk_i);
        chk("add_latency_valid", 32'(wb_valid_o), 32'd1);
        chk("add_ready", 32'(id_ready_o), 32'd1);
        cyc();

        // Back-to-back under backpressure fills OUT then SKID
        wb_ready_i = 1'b0;
        drive_wb(ALU_SUB, 32'd5, 32'd3, 5'd1, 1'b1, '{rd: 5'd1, we: 1'b1, data: 32'd2});
        cyc();
        drive_wb(ALU_XOR, 32'd5, 32'd3, 5'd2, 1'b1, '{rd: 5'd2, we: 1'b1, data: 32'd6});
        cyc(); idle();
        @(negedge clk_i);
        chk("full_ready", 32'(id_ready_o), 32'd0);
        chk("full_out_data", wb_data_o, 32'd2);
        cyc();
        chk("stall_hold_data", wb_data_o, 32'd2);
        wb_ready_i = 1'b1;
        cyc();
        @(negedge clk_i);
        chk("drained_ready", 32'(id_ready_o), 32'd1);
        chk("skid_to_out", wb_data_o, 32'd6);
        cyc();
        @(negedge clk_i);
        chk("empty_valid", 32'(wb_valid_o), 32'd0);
        cyc();

        // Branches: taken, not taken, target wrap
        drive_br(ALU_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, '{taken: 1'b1, target: 32'h120});
        cyc(); idle();
        @(negedge clk_i);
        chk("beq_pulse", 32'(br_valid_o), 32'd1);
        chk("beq_no_wb", 32'(wb_valid_o), 32'd0);
        cyc();
        @(negedge clk_i);
        chk("beq_pulse_end", 32'(br_valid_o), 32'd0);
        chk("beq_target_hold", br_target_o, 32'h120);
        cyc();
        drive_br(ALU_BNE, 32'd5, 32'd5, 32'h200, 32'h8, '{taken: 1'b0, target: 32'h208});
        cyc();
        drive_br(ALU_BLT, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, '{taken: 1'b1, target: 32'h10});
        cyc(); idle();
        @(negedge clk_i);
        chk("blt_wrap_target", br_target_o, 32'h10);
        cyc(); cyc();

        // Flush with both slots full and a new op on the input
        wb_ready_i = 1'b0;
        drive_wb(ALU_ADD, 32'd1, 32'd1, 5'd3, 1'b1, '{rd: 5'd3, we: 1'b1, data: 32'd2});
        cyc();
        drive_wb(ALU_ADD, 32'd10, 32'd20, 5'd4, 1'b1, '{rd: 5'd4, we: 1'b1, data: 32'd30});
        cyc();
        drive_wb(ALU_ADD, 32'd7, 32'd7, 5'd5, 1'b1, '{rd: 5'd5, we: 1'b1, data: 32'd14});
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("pre_flush_ready", 32'(id_ready_o), 32'd0);
        cyc();
        flush_i = 1'b0; idle(); wb_ready_i = 1'b1;
        @(negedge clk_i);
        chk("flush_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("flush_ready", 32'(id_ready_o), 32'd1);
        cyc(); cyc(); cyc();

        // rd=x0 is emitted with the write disarmed
        drive_wb(ALU_ADD, 32'd7, 32'd8, 5'd0, 1'b1, '{rd: 5'd0, we: 1'b0, data: 32'd15});
        cyc(); idle();
        @(negedge clk_i);
        chk("x0_valid", 32'(wb_valid_o), 32'd1);
        chk("x0_we", 32'(wb_rd_we_o), 32'd0);
        cyc();

        // Reset mid-operation: OUT held, branch presented alongside reset
        wb_ready_i = 1'b0;
        drive_wb(ALU_ADD, 32'd2, 32'd2, 5'd9, 1'b1, '{rd: 5'd9, we: 1'b1, data: 32'd4});
        cyc();
        drive_br(ALU_BEQ, 32'd1, 32'd1, 32'h40, 32'h4, '{taken: 1'b1, target: 32'h44});
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1; idle(); wb_ready_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_br_valid", 32'(br_valid_o), 32'd0);
        chk("midrst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("midrst_ready", 32'(id_ready_o), 32'd1);
        cyc(); cyc();

        @(negedge clk_i);
        chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        chk("br_queue_empty", 32'(br_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/salu_ex_stage.md
Name: salu_ex_stage

Overview:
- Execute-stage wrapper around the combinational scalar ALU (salu).
- Accepts decoded scalar ops from the issue/decode stage over a valid/ready handshake and drives the ALU operands.
- Registers the ALU result into a writeback slot backed by a 1-entry skid buffer, and resolves branches (taken/target) as a registered pulse to the fetch frontend.
- Sits between decode and writeback in the scalar pipe of the vector core.

Parameters:
- DATA_WIDTH, 32, operand/result/PC width.
- REG_ADDR_W, 5, architectural register index width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- flush_i  in  1  kill all in-flight entries and any same-cycle acceptance
- id_valid_i  in  1  decoded op valid
- id_ready_o  out  1  stage can accept
- id_alu_op_i  in  4  salu opcode (ADD..BGEU encoding, shared package)
- id_rs1_data_i  in  DATA_WIDTH  operand A
- id_rs2_data_i  in  DATA_WIDTH  operand B
- id_rd_addr_i  in  REG_ADDR_W  destination register
- id_rd_we_i  in  1  op writes rd
- id_is_branch_i  in  1  op is conditional branch (opcode must be BEQ..BGEU)
- id_pc_i  in  DATA_WIDTH  instruction PC
- id_imm_i  in  DATA_WIDTH  sign-extended branch offset
- alu_op_o  out  4  to salu, combinational pass of id_alu_op_i
- alu_rs1_o  out  DATA_WIDTH  to salu, pass of id_rs1_data_i
- alu_rs2_o  out  DATA_WIDTH  to salu, pass of id_rs2_data_i
- alu_res_i  in  DATA_WIDTH  salu result; for branch opcodes, bit0=1 means condition true
- wb_valid_o  out  1  writeback entry valid
- wb_ready_i  in  1  writeback accepts
- wb_rd_addr_o  out  REG_ADDR_W  destination
- wb_rd_we_o  out  1  write enable
- wb_data_o  out  DATA_WIDTH  result
- br_valid_o  out  1  one-cycle branch-resolution pulse
- br_taken_o  out  1  branch taken
- br_target_o  out  DATA_WIDTH  id_pc_i + id_imm_i, mod 2^DATA_WIDTH

Behaviour:
- Reset (rst_ni low at posedge):
  - All outputs/registers 0.
  - id_ready_o=1 in the cycle after reset deasserts.
- Storage: output register (OUT) and skid register (SKID), each with a valid bit.
- id_ready_o = !skid_valid (registered-derived; no combinational path from wb_ready_i).
- Accept: id_valid_i && id_ready_o && !flush_i.
- Non-branch accept:
  - Entry {rd_addr, rd_we & (rd_addr!=0), alu_res_i} is captured.
  - Goes to OUT if OUT is empty or draining this cycle (wb_valid_o && wb_ready_i) and SKID is empty; otherwise goes to SKID.
- Branch accept:
  - No writeback entry.
  - Next cycle: br_valid_o=1, br_taken_o=alu_res_i[0], br_target_o=pc+imm (registered).
  - br_valid_o is high for exactly one cycle per branch.
  - br_taken_o and br_target_o hold their last value when br_valid_o=0.
- Drain: on an OUT handshake, if SKID is valid, SKID moves to OUT and skid_valid clears in the same edge.
- A simultaneous accept in that cycle is impossible, because id_ready_o=0.
- Latency: accept to wb_valid_o is 1 cycle. Throughput is 1 op/cycle while wb_ready_i=1.
- Backpressure:
  - OUT is held stable while wb_valid_o && !wb_ready_i.
  - At most 2 entries are buffered. With both full, id_ready_o=0.
- Flush:
  - Next edge clears OUT valid, SKID valid and br_valid_o; this cycle's op is dropped.
  - Flush has priority over accept and drain. Data fields may keep stale values.
- rd_addr=0 with rd_we=1: entry still emitted, wb_rd_we_o=0.
- Reset mid-operation: identical to reset (all state cleared, pending branch pulse suppressed).
- Branch and non-branch are never accepted in the same cycle (single issue).

Decomposition:
- Package salu_pkg:
  - alu_op_e enum (ADD=0..BGEU=15)
  - is_branch_op() function
  - wb_entry_t struct {rd_addr, rd_we, data}
- One natural sub-module: salu_skid_buf, a generic 2-slot valid/ready register slice parameterised on payload type.
- salu itself is instantiated by the parent pipeline, not inside this block.

Test Plan:
- ADD 5,3 rd=x7 we=1, wb_ready_i=1 -> 1 cycle later wb_valid_o=1, wb_rd_addr_o=7, wb_data_o=8, wb_rd_we_o=1; id_ready_o stays 1.
- Back-to-back SUB 5,3 then XOR 5,3 with wb_ready_i=0 -> OUT=2, SKID=6, id_ready_o=0. Raise wb_ready_i -> emits 2 then 6 on consecutive cycles; id_ready_o returns to 1 after SKID drains.
- BEQ 5,5 pc=0x100 imm=0x20 -> next cycle br_valid_o=1 for 1 cycle, br_taken_o=1, br_target_o=0x120, no wb_valid_o. BNE 5,5 gives br_taken_o=0.
- Wrap: BLT pc=0xFFFFFFF0 imm=0x20 -> br_target_o=0x00000010.
- Flush with OUT and SKID full plus id_valid_i=1 -> next cycle wb_valid_o=0, id_ready_o=1, and no later emission of any dropped op.
- ADD rd=x0 we=1 -> wb_valid_o=1, wb_rd_we_o=0. rst_ni low while br pulse pending -> br_valid_o=0, wb_valid_o=0 next cycle.
